// File: rtl/cva6_credit_tx.sv
// cva6_credit_tx: credit-based transmitter feeding the push side of a remote
// cva6_fifo_v3. One credit per free remote slot; a credit is spent on every
// accepted beat and recovered on every remote pop. A drain handshake lets the
// producer quiesce the link (all credits home) before a flush.
//
// Build option: define CVA6_CREDIT_TX_OUTREG_EN to register push_o/data_o
// (one cycle of latency); otherwise they are a combinational pass-through.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   valid_i/ready_o    producer stream handshake (ready_o from state only)
//   data_i             producer payload
//   push_o/data_o      push strobe and payload to the remote FIFO
//   credit_i           one credit returned (remote pop & ~empty)
//   credits_o          registered credit count
//   flush_req_i        drain request (level)
//   flush_ack_o        one-cycle pulse once the link is drained
//   err_o              sticky credit-overflow flag
module cva6_credit_tx #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter type         dtype      = logic [DATA_WIDTH-1:0]
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  dtype                         data_i,
    output logic                         push_o,
    output dtype                         data_o,
    input  logic                         credit_i,
    output logic [$clog2(DEPTH+1)-1:0]   credits_o,
    input  logic                         flush_req_i,
    output logic                         flush_ack_o,
    output logic                         err_o
);

    localparam int unsigned CREDIT_W = $clog2(DEPTH + 1);

    typedef logic [CREDIT_W-1:0] credit_t;

    localparam credit_t CREDIT_MAX = credit_t'(DEPTH);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_ACK    = 2'd2
    } state_e;

    state_e  state_q, state_d;
    credit_t credits_q, credits_d;
    logic    err_q, err_d;
    logic    transfer;
    logic    drain_clear;

    // Acceptance, credit accounting and drain state machine.
    always_comb begin
        state_d   = state_q;
        credits_d = credits_q;
        err_d     = err_q;
        ready_o   = (state_q == ST_ACTIVE) && (credits_q != '0);
        transfer  = valid_i & ready_o;

        // A spend and a return in the same cycle cancel out.
        if (transfer && !credit_i) begin
            credits_d = credits_q - credit_t'(1);
        end else if (!transfer && credit_i) begin
            if (credits_q == CREDIT_MAX) begin
                err_d = 1'b1;
            end else begin
                credits_d = credits_q + credit_t'(1);
            end
        end

        case (state_q)
            ST_DRAIN: begin
                if ((credits_q == CREDIT_MAX) && drain_clear) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_ACTIVE;
            end
            default: begin
                if (flush_req_i) begin
                    state_d = ST_DRAIN;
                end
            end
        endcase
    end

    // State, credit and error registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_ACTIVE;
            credits_q <= CREDIT_MAX;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            credits_q <= credits_d;
            err_q     <= err_d;
        end
    end

    assign credits_o   = credits_q;
    assign flush_ack_o = (state_q == ST_ACK);
    assign err_o       = err_q;

`ifdef CVA6_CREDIT_TX_OUTREG_EN
    logic push_q, push_d;
    dtype data_q, data_d;

    // Output register: payload only updates on an accepted beat.
    always_comb begin
        push_d = transfer;
        data_d = data_q;
        if (transfer) begin
            data_d = data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            push_q <= 1'b0;
            data_q <= '0;
        end else begin
            push_q <= push_d;
            data_q <= data_d;
        end
    end

    assign push_o      = push_q;
    assign data_o      = data_q;
    // A beat still sitting in the output register has not reached the FIFO.
    assign drain_clear = ~push_q;
`else
    assign push_o      = transfer;
    assign data_o      = data_i;
    assign drain_clear = 1'b1;
`endif

endmodule

// File: tb/tb_cva6_credit_tx.sv
// Self-checking bench for cva6_credit_tx (DEPTH=8, 32-bit payload).
module tb_cva6_credit_tx;

    localparam int DEPTH = 8;
`ifdef CVA6_CREDIT_TX_OUTREG_EN
    localparam bit OUTREG = 1'b1;
`else
    localparam bit OUTREG = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] data_i = '0;
    logic        push_o;
    logic [31:0] data_o;
    logic        credit_i = 1'b0;
    logic [3:0]  credits_o;
    logic        flush_req_i = 1'b0;
    logic        flush_ack_o;
    logic        err_o;

    cva6_credit_tx #(
        .DATA_WIDTH (32),
        .DEPTH      (DEPTH)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .data_i      (data_i),
        .push_o      (push_o),
        .data_o      (data_o),
        .credit_i    (credit_i),
        .credits_o   (credits_o),
        .flush_req_i (flush_req_i),
        .flush_ack_o (flush_ack_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: free remote slots as a plain count, plus drain bookkeeping.
    int  m_credits = DEPTH;
    bit  m_draining = 1'b0;
    bit  m_acking = 1'b0;
    bit  m_err = 1'b0;
    bit  m_pend = 1'b0;
    int  m_pend_data = 0;
    int  push_log[$];
    int  n_ack = 0;

    // Compare process: inputs are stable and outputs settled mid-cycle.
    always begin
        bit e_ready;
        bit xfer;
        bit e_push;
        int e_data;
        int nxt;
        @(negedge clk_i);
        #3;
        if (!rst_ni) begin
            m_credits   = DEPTH;
            m_draining  = 1'b0;
            m_acking    = 1'b0;
            m_err       = 1'b0;
            m_pend      = 1'b0;
            m_pend_data = 0;
        end
        e_ready = !m_draining && !m_acking && (m_credits > 0);
        xfer    = valid_i && e_ready;
        e_push  = OUTREG ? m_pend : xfer;
        e_data  = OUTREG ? m_pend_data : int'(data_i);
        chk("ready_o", int'(ready_o), int'(e_ready));
        chk("push_o", int'(push_o), int'(e_push));
        if (e_push) chk("data_o", int'(data_o), e_data);
        chk("credits_o", int'(credits_o), m_credits);
        chk("flush_ack_o", int'(flush_ack_o), int'(m_acking));
        chk("err_o", int'(err_o), int'(m_err));
        if (push_o) push_log.push_back(int'(data_o));
        if (flush_ack_o) n_ack++;
        if (rst_ni) begin
            nxt = m_credits - int'(xfer) + int'(credit_i);
            if (nxt > DEPTH) begin
                nxt   = DEPTH;
                m_err = 1'b1;
            end
            if (m_acking) begin
                m_acking = 1'b0;
            end else if (m_draining) begin
                if (m_credits == DEPTH && !(OUTREG && m_pend)) begin
                    m_draining = 1'b0;
                    m_acking   = 1'b1;
                end
            end else if (flush_req_i) begin
                m_draining = 1'b1;
            end
            m_credits = nxt;
            m_pend    = xfer;
            if (xfer) m_pend_data = int'(data_i);
        end
    end

    // Drive one cycle of inputs; acc reports whether the beat is accepted.
    task automatic cyc(input bit v, input int d, input bit c, input bit f, output bit acc);
        @(negedge clk_i);
        #1;
        valid_i     = v;
        data_i      = 32'(d);
        credit_i    = c;
        flush_req_i = f;
        acc         = v & ready_o;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        #1;
        rst_ni      = 1'b0;
        valid_i     = 1'b0;
        credit_i    = 1'b0;
        flush_req_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        bit acc;
        int beat;

        do_reset();
        cyc(0, 0, 0, 0, acc);
        chk("reset_credits", int'(credits_o), 8);
        chk("reset_ready", int'(ready_o), 1);
        chk("reset_push", int'(push_o), 0);
        chk("reset_err", int'(err_o), 0);

        // Exhaust credits with 10 beats and no returns.
        push_log.delete();
        beat = 0;
        for (int i = 0; i < 14; i++) begin
            cyc(beat < 10, beat, 0, 0, acc);
            if (acc) beat++;
        end
        chk("exhaust_accepted", beat, 8);
        chk("exhaust_pushes", push_log.size(), 8);
        for (int i = 0; i < 8 && i < push_log.size(); i++) chk("exhaust_data", push_log[i], i);
        chk("exhaust_ready", int'(ready_o), 0);
        chk("exhaust_credits", int'(credits_o), 0);

        // One credit back lets beat 8 through.
        cyc(0, 0, 1, 0, acc);
        cyc(1, 8, 0, 0, acc);
        chk("recover_accept", int'(acc), 1);
        cyc(0, 0, 0, 0, acc);
        cyc(0, 0, 0, 0, acc);
        chk("recover_credits", int'(credits_o), 0);
        chk("recover_pushes", push_log.size(), 9);
        if (push_log.size() == 9) chk("recover_data", push_log[8], 8);

        // Bring credits to 3, then transfer and return every cycle.
        repeat (3) cyc(0, 0, 1, 0, acc);
        for (int i = 0; i < 20; i++) cyc(1, int'($urandom), 1, 0, acc);
        cyc(0, 0, 0, 0, acc);
        chk("steady_credits", int'(credits_o), 3);

        // Drain with 5 outstanding; request dropped early.
        n_ack = 0;
        cyc(0, 0, 0, 1, acc);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1, i < 2, acc);
            cyc(0, 0, 0, 0, acc);
        end
        repeat (4) cyc(0, 0, 0, 0, acc);
        chk("drain_acks", n_ack, 1);
        chk("drain_credits", int'(credits_o), 8);
        chk("drain_ready", int'(ready_o), 1);

        // Random traffic with well-behaved credit returns and flush pulses.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 4) != 0, int'($urandom),
                (m_credits < DEPTH) && (($urandom % 3) != 0),
                ($urandom % 24) == 0, acc);
        end
        for (int i = 0; i < 40; i++) cyc(0, 0, m_credits < DEPTH, 0, acc);
        repeat (3) cyc(0, 0, 0, 0, acc);
        chk("refill_credits", int'(credits_o), 8);

        // Overflow: return a credit while full.
        cyc(0, 0, 1, 0, acc);
        cyc(0, 0, 0, 0, acc);
        chk("ovf_credits", int'(credits_o), 8);
        chk("ovf_err", int'(err_o), 1);
        for (int i = 0; i < 30; i++) begin
            cyc(($urandom % 2) != 0, int'($urandom), ($urandom % 2) != 0, 0, acc);
        end
        chk("ovf_sticky", int'(err_o), 1);

        // Reset mid-stream.
        cyc(1, 32'h55, 0, 0, acc);
        do_reset();
        cyc(0, 0, 0, 0, acc);
        chk("rst2_credits", int'(credits_o), 8);
        chk("rst2_err", int'(err_o), 0);
        chk("rst2_ready", int'(ready_o), 1);
        chk("rst2_push", int'(push_o), 0);
        chk("rst2_ack", int'(flush_ack_o), 0);
        repeat (3) cyc(0, 0, 0, 0, acc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
